// File: rtl/axi4l_cmd_master.sv
// AXI4-Lite command master: queues write/read commands in a FIFO, runs one
// AXI4-Lite transaction at a time and returns one response per command.
// A transaction that gets no answer within P_TIMEOUT cycles is closed locally
// with a SLVERR-coded timeout response.
module axi4l_cmd_master #(
    parameter int P_ADDR_WIDTH = 8,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_FIFO_DEPTH = 4,
    parameter int P_TIMEOUT    = 255
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [P_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [P_DATA_WIDTH-1:0]   cmd_data,
    input  logic [P_DATA_WIDTH/8-1:0] cmd_strb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [P_DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic                      m_awvalid,
    output logic [P_ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]                m_awprot,
    input  logic                      m_awready,
    output logic                      m_wvalid,
    output logic [P_DATA_WIDTH-1:0]   m_wdata,
    output logic [P_DATA_WIDTH/8-1:0] m_wstrb,
    input  logic                      m_wready,
    input  logic                      m_bvalid,
    input  logic [1:0]                m_bresp,
    output logic                      m_bready,
    output logic                      m_arvalid,
    output logic [P_ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]                m_arprot,
    input  logic                      m_arready,
    input  logic                      m_rvalid,
    input  logic [P_DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]                m_rresp,
    output logic                      m_rready
);

    localparam int SW = P_DATA_WIDTH / 8;
    localparam int PW = (P_FIFO_DEPTH > 1) ? $clog2(P_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(P_FIFO_DEPTH + 1);
    localparam int TW = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RRESP, S_RSP
    } state_t;

    state_t state;

    logic                    fifo_write [P_FIFO_DEPTH];
    logic [P_ADDR_WIDTH-1:0] fifo_addr  [P_FIFO_DEPTH];
    logic [P_DATA_WIDTH-1:0] fifo_data  [P_FIFO_DEPTH];
    logic [SW-1:0]           fifo_strb  [P_FIFO_DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          push, pop, active_next;
    logic [TW-1:0] tcnt;
    logic          tout;
    logic          aw_done, w_done, aw_hs, w_hs, ar_hs;

    assign m_awprot = 3'b000;
    assign m_arprot = 3'b000;

    // Handshake decode, FIFO occupancy and FSM-activity look-ahead for the registered flags
    always_comb begin
        push        = cmd_valid && cmd_ready;
        pop         = (state == S_IDLE) && (count != '0);
        aw_hs       = m_awvalid && m_awready;
        w_hs        = m_wvalid && m_wready;
        ar_hs       = m_arvalid && m_arready;
        tout        = (P_TIMEOUT != 0) && (tcnt == TW'(P_TIMEOUT));
        count_next  = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
        if (state == S_IDLE) begin
            active_next = pop;
        end else begin
            active_next = !((state == S_RSP) && rsp_valid && rsp_ready);
        end
    end

    // FIFO pointers, count and the registered cmd_ready/busy flags
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count     <= count_next;
            cmd_ready <= (count_next != CW'(P_FIFO_DEPTH));
            busy      <= (count_next != '0) || active_next;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge ACLK) begin
        if (push) begin
            fifo_write[wr_ptr] <= cmd_write;
            fifo_addr[wr_ptr]  <= cmd_addr;
            fifo_data[wr_ptr]  <= cmd_data;
            fifo_strb[wr_ptr]  <= cmd_strb;
        end
    end

    // Transaction FSM with registered AXI and response outputs
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= S_IDLE;
            m_awvalid   <= 1'b0;
            m_awaddr    <= '0;
            m_wvalid    <= 1'b0;
            m_wdata     <= '0;
            m_wstrb     <= '0;
            m_bready    <= 1'b0;
            m_arvalid   <= 1'b0;
            m_araddr    <= '0;
            m_rready    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_data    <= '0;
            rsp_resp    <= 2'b00;
            rsp_timeout <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            tcnt        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        tcnt        <= '0;
                        rsp_write   <= fifo_write[rd_ptr];
                        rsp_timeout <= 1'b0;
                        if (fifo_write[rd_ptr]) begin
                            m_awaddr  <= fifo_addr[rd_ptr];
                            m_wdata   <= fifo_data[rd_ptr];
                            m_wstrb   <= fifo_strb[rd_ptr];
                            m_awvalid <= 1'b1;
                            m_wvalid  <= 1'b1;
                            aw_done   <= 1'b0;
                            w_done    <= 1'b0;
                            state     <= S_WADDR;
                        end else begin
                            m_araddr  <= fifo_addr[rd_ptr];
                            m_arvalid <= 1'b1;
                            state     <= S_RADDR;
                        end
                    end
                end
                S_WADDR: begin
                    tcnt <= tcnt + 1'b1;
                    if (aw_hs) begin
                        m_awvalid <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        m_wvalid <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        m_bready <= 1'b1;
                        state    <= S_WRESP;
                    end else if (tout) begin
                        m_awvalid   <= 1'b0;
                        m_wvalid    <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_resp    <= 2'b10;
                        rsp_data    <= '0;
                        state       <= S_RSP;
                    end
                end
                S_WRESP: begin
                    tcnt <= tcnt + 1'b1;
                    if (m_bvalid) begin
                        m_bready  <= 1'b0;
                        rsp_resp  <= m_bresp;
                        rsp_data  <= '0;
                        rsp_valid <= 1'b1;
                        state     <= S_RSP;
                    end else if (tout) begin
                        m_bready    <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_resp    <= 2'b10;
                        rsp_data    <= '0;
                        state       <= S_RSP;
                    end
                end
                S_RADDR: begin
                    tcnt <= tcnt + 1'b1;
                    if (ar_hs) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= S_RRESP;
                    end else if (tout) begin
                        m_arvalid   <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_resp    <= 2'b10;
                        rsp_data    <= '0;
                        state       <= S_RSP;
                    end
                end
                S_RRESP: begin
                    tcnt <= tcnt + 1'b1;
                    if (m_rvalid) begin
                        m_rready  <= 1'b0;
                        rsp_data  <= m_rdata;
                        rsp_resp  <= m_rresp;
                        rsp_valid <= 1'b1;
                        state     <= S_RSP;
                    end else if (tout) begin
                        m_rready    <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_resp    <= 2'b10;
                        rsp_data    <= '0;
                        state       <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi4l_cmd_master.md
# axi4l_cmd_master

Synthesizable AXI4-Lite master that replaces the task-driven stimulus used around the `base` register block. It supports both writes and reads, drives AW and W concurrently, buffers commands in a parametrised FIFO and detects response timeouts. Commands enter through a valid/ready port, and one response is returned per command on a valid/ready port. The block sits between a test sequencer or soft controller and any AXI4-Lite slave in the design, such as `base`.

## Interface
Parameters:
- P_ADDR_WIDTH, 8, AXI address width
- P_DATA_WIDTH, 32, AXI data width (32 or 64)
- P_FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- P_TIMEOUT, 255, cycles allowed from issue to response (0 disables timeout)

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  P_ADDR_WIDTH  target address
- cmd_data  in  P_DATA_WIDTH  write data (ignored for reads)
- cmd_strb  in  P_DATA_WIDTH/8  write strobes
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_write  out  1  echo of cmd_write
- rsp_data  out  P_DATA_WIDTH  read data (0 for writes and timeouts)
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
- rsp_timeout  out  1  response produced by timeout
- busy  out  1  FIFO non-empty or FSM not IDLE
- m_awvalid, m_awaddr[P_ADDR_WIDTH], m_awprot[3]  out; m_awready  in
- m_wvalid, m_wdata[P_DATA_WIDTH], m_wstrb[P_DATA_WIDTH/8]  out; m_wready  in
- m_bvalid, m_bresp[2]  in; m_bready  out
- m_arvalid, m_araddr[P_ADDR_WIDTH], m_arprot[3]  out; m_arready  in
- m_rvalid, m_rdata[P_DATA_WIDTH], m_rresp[2]  in; m_rready  out

## Operation
- **Command FIFO.** Push on cmd_valid&&cmd_ready. cmd_ready = !full; there is no bypass when full, even if a pop occurs in the same cycle. Pointers wrap modulo P_FIFO_DEPTH. Push and pop in the same cycle keep the count unchanged.
- **FSM states:** IDLE, WADDR, WRESP, RADDR, RRESP, RSP.
  - IDLE pops when the FIFO is non-empty. It goes to WADDR if cmd_write, otherwise RADDR.
  - WADDR asserts m_awvalid and m_wvalid together. Each valid is dropped independently on its handshake, tracked by aw_done/w_done. When both are done, go to WRESP.
  - WRESP asserts m_bready. On m_bvalid, capture m_bresp and go to RSP.
  - RADDR asserts m_arvalid. On m_arready, go to RRESP.
  - RRESP asserts m_rready. On m_rvalid, capture m_rdata and m_rresp and go to RSP.
  - RSP asserts rsp_valid. On rsp_ready, go to IDLE.
- Only one transaction is outstanding at a time. m_awprot and m_arprot are constant 3'b000.
- **Timeout.** The counter clears on leaving IDLE and counts in WADDR, WRESP, RADDR and RRESP. On reaching P_TIMEOUT:
  - deassert all m_*valid, m_bready and m_rready;
  - set rsp_timeout=1, rsp_resp=2'b10, rsp_data=0;
  - go to RSP.
- B or R beats arriving outside WRESP or RRESP are ignored.
- An error response (SLVERR or DECERR) is reported unchanged; it is not a timeout. For reads, rsp_data is still captured.

## Timing
- **Reset values:**
  - all m_*valid, m_bready, m_rready = 0;
  - rsp_valid = 0, busy = 0, cmd_ready = 1;
  - all address, data and response outputs = 0.
- ARESETN assertion mid-transaction aborts immediately: FIFO emptied, FSM to IDLE, valids drop asynchronously, and no response is produced.
- All outputs are registered.
- **AXI valid rules:** a valid, once asserted, holds with stable payload until its ready, except on timeout or reset. Valid never depends combinationally on ready.
- **Response payload:** rsp_* is stable while rsp_valid && !rsp_ready.
- **Latency with a zero-wait slave** (readies high; bvalid/rvalid registered one cycle after the address phase):
  - command accepted at edge N;
  - m_*valid visible after edge N+1;
  - address handshake at N+2;
  - response handshake at N+3;
  - rsp_valid visible after N+3.
- Back-to-back commands: the next command's valid appears one cycle after the rsp handshake edge.
- Timeout: with P_TIMEOUT=T and a silent slave, rsp_valid rises T+1 cycles after the valids assert.

## Test plan
- **Zero-wait write.** Write 0x10 ← 0xDEADBEEF, strb 0xF. Expect:
  - AW and W in the same cycle, m_awaddr=0x10, m_wdata=0xDEADBEEF;
  - rsp_valid 3 cycles after acceptance, rsp_resp=0, rsp_timeout=0.
- **Skewed AW/W.** m_wready delayed 3 cycles. Expect:
  - m_awvalid drops after its handshake while m_wvalid holds;
  - exactly one B accepted; rsp issued after B.
- **Read with error.** Read 0x04; slave returns rdata 0x0000A5A5, rresp 2'b10. Expect rsp_data=0x0000A5A5, rsp_resp=2'b10, rsp_timeout=0.
- **Back-pressure and full FIFO.** Hold rsp_ready=0 and push 5 commands with depth 4. Expect:
  - cmd_ready=0 after 4 FIFO entries plus 1 in flight;
  - releasing rsp_ready returns all responses in order.
- **Timeout.** P_TIMEOUT=8, slave never asserts m_awready. Expect:
  - valids drop after 8 cycles;
  - rsp_timeout=1, rsp_resp=2'b10, rsp_data=0;
  - a late m_bvalid is ignored.
- **Reset mid-operation.** Assert ARESETN low in RRESP with 2 commands queued. Expect:
  - all valids 0 immediately, busy=0, no rsp_valid;
  - after release, a new command completes normally.
